// File: rtl/cmem_sym_dbuf.sv
// Double-buffered FIR coefficient memory: the host loads a shadow bank while the
// filter reads the active one. Reads fold the tap index so that only half of a
// symmetric response is stored. Define CMEM_ASYM_EN for full-length banks with
// no folding.
module cmem_sym_dbuf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH),
`ifdef CMEM_ASYM_EN
    localparam int HAW = AW
`else
    localparam int HAW = AW - 1
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [HAW-1:0]   wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             swap_req,
    output logic             swap_done,
    output logic             loaded
);
    localparam int NW = 1 << HAW;

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    logic [WIDTH-1:0] bank_mem [0:1][0:NW-1];

    state_t           state_q, state_d;
    logic             active_q, active_d;
    logic             loaded_q, loaded_d;
    logic             wr_ready_q, wr_ready_d;
    logic             swap_done_q, swap_done_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [HAW-1:0]   rd_idx;
    logic [WIDTH-1:0] rd_word;
    logic             wr_fire;

    // Upper-half taps mirror onto the lower half: DEPTH-1-a == ~a on the low bits.
    always_comb begin
`ifdef CMEM_ASYM_EN
        rd_idx = rd_addr;
`else
        rd_idx = rd_addr[AW-1] ? ~rd_addr[HAW-1:0] : rd_addr[HAW-1:0];
`endif
    end

    assign rd_word = bank_mem[active_q][rd_idx];
    assign wr_fire = wr_en & wr_ready_q;

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        loaded_d    = loaded_q;
        wr_ready_d  = wr_ready_q;
        swap_done_d = 1'b0;
        rd_valid_d  = rd_en;
        rd_data_d   = rd_data_q;
        if (rd_en) begin
            rd_data_d = loaded_q ? rd_word : '0;
        end
        case (state_q)
            IDLE: begin
                if (swap_req) begin
                    state_d    = PEND;
                    wr_ready_d = 1'b0;
                end
            end
            PEND: begin
                // Toggle only in a read-free cycle so no read straddles the banks.
                if (!rd_en) begin
                    state_d     = IDLE;
                    active_d    = ~active_q;
                    loaded_d    = 1'b1;
                    swap_done_d = 1'b1;
                    wr_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            active_q    <= 1'b0;
            loaded_q    <= 1'b0;
            wr_ready_q  <= 1'b1;
            swap_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            loaded_q    <= loaded_d;
            wr_ready_q  <= wr_ready_d;
            swap_done_q <= swap_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank_mem[~active_q][wr_addr] <= wr_data;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign wr_ready  = wr_ready_q;
    assign swap_done = swap_done_q;
    assign loaded    = loaded_q;
endmodule

// File: tb/tb_cmem_sym_dbuf.sv
// Scoreboard bench for cmem_sym_dbuf: the driver pushes expectations from an
// array-level model, a negedge monitor pops and compares.
module tb_cmem_sym_dbuf;
  localparam int WIDTH = 16;
  localparam int DEPTH = 64;
  localparam int AW = 6;
`ifdef CMEM_ASYM_EN
  localparam int HAW = AW;
`else
  localparam int HAW = AW - 1;
`endif
  localparam int NW = 1 << HAW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [WIDTH-1:0] rd_data;
  logic rd_valid;
  logic wr_en = 1'b0;
  logic [HAW-1:0] wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic wr_ready;
  logic swap_req = 1'b0;
  logic swap_done;
  logic loaded;

  cmem_sym_dbuf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .swap_req(swap_req), .swap_done(swap_done), .loaded(loaded)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    logic [WIDTH-1:0] data;
    bit known;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int sw_q[$];
  logic [WIDTH-1:0] obs_q[$];

  // Reference model: two plain word arrays plus which one the filter sees.
  logic [WIDTH-1:0] m_bank[2][NW];
  bit m_known[2][NW];
  int m_act = 0;
  bit m_loaded = 0, m_pend = 0, m_wr_ready = 1;

  logic [WIDTH-1:0] mon_last = '0;
  bit mon_known = 1;
  rd_exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int fold(input int a);
`ifdef CMEM_ASYM_EN
    return a;
`else
    return (a < DEPTH / 2) ? a : DEPTH - 1 - a;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_swap_done", swap_done, 0);
      chk("rst_loaded", loaded, 0);
      chk("rst_wr_ready", wr_ready, 1);
    end else begin
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        mon_e = rd_q.pop_front();
        chk("rd_valid", rd_valid, 1);
        if (mon_e.known) chk("rd_data", rd_data, mon_e.data);
        if (rd_valid) obs_q.push_back(rd_data);
        mon_last = mon_e.data;
        mon_known = mon_e.known;
      end else begin
        chk("rd_valid_idle", rd_valid, 0);
        if (mon_known) chk("rd_data_hold", rd_data, mon_last);
      end
      if (sw_q.size() > 0 && sw_q[0] == cyc) begin
        void'(sw_q.pop_front());
        chk("swap_done", swap_done, 1);
      end else begin
        chk("swap_done_idle", swap_done, 0);
      end
      chk("loaded", loaded, m_loaded);
      chk("wr_ready", wr_ready, m_wr_ready);
    end
  end

  // One clock of stimulus; the model advances at the same edge as the DUT.
  task automatic step(input bit re, input int ra, input bit we, input int wa,
                      input logic [WIDTH-1:0] wd, input bit sr);
    int nact;
    bit nload, npend, nwr;
    rd_exp_t e;
    int ix;
    rd_en = re; rd_addr = ra[AW-1:0];
    wr_en = we; wr_addr = wa[HAW-1:0]; wr_data = wd;
    swap_req = sr;
    nact = m_act; nload = m_loaded; npend = m_pend; nwr = m_wr_ready;
    if (re) begin
      ix = fold(ra);
      e.due = cyc + 1;
      e.data = m_loaded ? m_bank[m_act][ix] : '0;
      e.known = m_loaded ? m_known[m_act][ix] : 1'b1;
      rd_q.push_back(e);
    end
    if (we && m_wr_ready) begin
      m_bank[1 - m_act][wa] = wd;
      m_known[1 - m_act][wa] = 1'b1;
    end
    if (!m_pend && sr) begin
      npend = 1; nwr = 0;
    end else if (m_pend && !re) begin
      npend = 0; nwr = 1; nact = 1 - m_act; nload = 1;
      sw_q.push_back(cyc + 1);
    end
    @(posedge clk);
    m_act = nact; m_loaded = nload; m_pend = npend; m_wr_ready = nwr;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0);
  endtask

  task automatic rd(input int a);
    step(1, a, 0, 0, '0, 0);
  endtask

  task automatic do_swap();
    step(0, 0, 0, 0, '0, 1);
    idle(2);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NW; i++) step(0, 0, 1, i, WIDTH'($urandom), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rd_en = 0; wr_en = 0; swap_req = 0;
    rd_q.delete(); sw_q.delete();
    m_act = 0; m_loaded = 0; m_pend = 0; m_wr_ready = 1;
    mon_last = '0; mon_known = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [WIDTH-1:0] tv;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NW; i++) begin
        m_bank[b][i] = '0; m_known[b][i] = 0;
      end
    do_reset();

    // Reads before any swap return zero.
    rd(5);
    idle(2);

    // Load the documented coefficient table, swap, check mirrored reads.
    for (int i = 0; i < NW; i++) begin
      case (i)
        0, 1: tv = 16'hFFFF;
        2: tv = 16'h0001;
        3: tv = 16'h0003;
        29: tv = 16'h0B2B;
        30: tv = 16'h1A91;
        31: tv = 16'h2500;
        default: tv = WIDTH'(i * 16'h0101);
      endcase
      step(0, 0, 1, i, tv, 0);
    end
    do_swap();
    rd(31); rd(32); rd(29); rd(34); rd(63); rd(60);
    idle(2);

    // Swap pending under continuous reads; dropped write in PEND.
    fill_rand();
    if (m_bank[1 - m_act][0] == 16'h1234) step(0, 0, 1, 0, 16'h4321, 0);
    step(1, $urandom_range(0, DEPTH - 1), 0, 0, '0, 1);
    step(1, $urandom_range(0, DEPTH - 1), 1, 0, 16'h1234, 0);
    for (int i = 0; i < 6; i++) step(1, $urandom_range(0, DEPTH - 1), 0, 0, '0, 1);
    idle(1);
    rd(0); rd(63); rd(17);
    idle(2);

    // Back-to-back sweep, then symmetry of the captured words.
    obs_q.delete();
    for (int a = 0; a < DEPTH; a++) rd(a);
    idle(2);
    chk("sweep_count", obs_q.size(), DEPTH);
`ifndef CMEM_ASYM_EN
    if (obs_q.size() == DEPTH)
      for (int k = 0; k < DEPTH / 2; k++) chk("sweep_mirror", obs_q[k], obs_q[DEPTH - 1 - k]);
`endif

    // Reset while a swap is pending, with a read in flight.
    step(1, 5, 0, 0, '0, 1);
    do_reset();
    rd(5);
    idle(2);
    fill_rand();
    do_swap();
    rd(3); rd(40);
    idle(2);

`ifdef CMEM_ASYM_EN
    fill_rand();
    step(0, 0, 1, 32, 16'h7FFF, 0);
    step(0, 0, 1, 31, 16'h2500, 0);
    do_swap();
    rd(32); rd(31);
    idle(2);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 1) == 1, $urandom_range(0, NW - 1),
           WIDTH'($urandom), $urandom_range(0, 7) == 0);
    idle(4);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("sw_q_empty", sw_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
